code5_tx: RTL and testbench

Serial transmitter for the team's 5-bit parity-protected BCD code. It accepts one BCD digit per handshake and forms the codeword A,B,C,D,E. A..D is the digit, MSB first, and E is the even-parity bit, so the total count of ones is always even. It then shifts the codeword out on a single line, framed by a start and a stop bit. It sits upstream of the existing combinational codeword checker and produces exactly the words that checker validates.

---
 rtl/code5_pkg.sv | 18 +
 rtl/code5_enc.sv | 13 +
 rtl/code5_tx.sv | 116 +++++++++++
 tb/tb_code5_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/code5_pkg.sv
// rtl/code5_pkg.sv - shared types and helpers for the 5-bit parity-protected BCD code
package code5_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int CODE_W  = 5;
  localparam int BCD_MAX = 9;

  function automatic logic parity_even(input logic [3:0] digit);
    return ^digit;
  endfunction

endpackage

// File: rtl/code5_enc.sv
// rtl/code5_enc.sv - combinational BCD digit to {A,B,C,D,E} codeword encoder
module code5_enc
  import code5_pkg::*;
(
  input  logic [3:0]        din_i,
  output logic [CODE_W-1:0] codeword_o,
  output logic              valid_o
);

  assign codeword_o = {din_i, parity_even(din_i)};
  assign valid_o    = (din_i <= 4'(BCD_MAX));

endmodule

// File: rtl/code5_tx.sv
// rtl/code5_tx.sv - framed serial transmitter for the 5-bit parity-protected BCD code
module code5_tx
  import code5_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic [CODE_W-1:0] code,
  output logic              err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          bit_idx_q;
  logic [CODE_W-1:0]   code_q;
  logic                tx_q;
  logic                busy_q;
  logic                err_q;

  logic [CODE_W-1:0]   enc_code;
  logic                enc_valid;
  logic                cnt_done;

  code5_enc u_enc (
    .din_i      (din),
    .codeword_o (enc_code),
    .valid_o    (enc_valid)
  );

  assign cnt_done  = (cnt_q == CNT_MAX);
  assign din_ready = (state_q == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      code_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (din_valid) begin
            // An out-of-range digit is consumed but only flagged; the line stays idle.
            if (enc_valid) begin
              state_q   <= START;
              code_q    <= enc_code;
              cnt_q     <= '0;
              bit_idx_q <= '0;
              tx_q      <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        START: begin
          if (cnt_done) begin
            state_q <= DATA;
            cnt_q   <= '0;
            tx_q    <= code_q[CODE_W-1];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_done) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd4) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= code_q[3'd3 - bit_idx_q];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_done) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign code = code_q;
  assign err  = err_q;

endmodule

// File: tb/tb_code5_tx.sv
// tb/tb_code5_tx.sv - directed self-checking bench for code5_tx at N=4 and N=1
module tb_code5_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din4, din1;
  logic       dv4, dv1;
  logic       rdy4, rdy1, tx4, tx1, busy4, busy1, err4, err1;
  logic [4:0] code4, code1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  code5_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .din(din4), .din_valid(dv4), .din_ready(rdy4),
    .tx(tx4), .busy(busy4), .code(code4), .err(err4)
  );

  code5_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(dv1), .din_ready(rdy1),
    .tx(tx1), .busy(busy1), .code(code1), .err(err1)
  );

  task automatic sample(input bit sel, output logic t_o, output logic b_o, output logic r_o,
                        output logic e_o, output logic [4:0] c_o);
    t_o = sel ? tx1   : tx4;
    b_o = sel ? busy1 : busy4;
    r_o = sel ? rdy1  : rdy4;
    e_o = sel ? err1  : err4;
    c_o = sel ? code1 : code4;
  endtask

  // Called at cycle t+1 of a frame; checks every cycle through the first idle cycle t+7N+1.
  task automatic check_frame(input bit sel, input int n, input logic [4:0] exp_code, input string name);
    logic t_, b_, r_, e_, exp_tx;
    logic [4:0] c_;
    int k;
    for (int c = 1; c <= 7*n + 1; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      sample(sel, t_, b_, r_, e_, c_);
      if (c <= n) exp_tx = 1'b0;
      else if (c <= 6*n) begin
        k = (c - 1) / n - 1;
        exp_tx = exp_code[4 - k];
      end else exp_tx = 1'b1;
      tests_run++;
      if (t_ !== exp_tx) begin
        tests_failed++;
        $display("FAIL %s tx cycle t+%0d: got %b want %b", name, c, t_, exp_tx);
      end
      tests_run++;
      if (b_ !== (c <= 7*n)) begin
        tests_failed++;
        $display("FAIL %s busy cycle t+%0d: got %b want %b", name, c, b_, (c <= 7*n));
      end
      tests_run++;
      if (r_ !== (c == 7*n + 1)) begin
        tests_failed++;
        $display("FAIL %s din_ready cycle t+%0d: got %b want %b", name, c, r_, (c == 7*n + 1));
      end
      tests_run++;
      if (e_ !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s err cycle t+%0d: got %b want 0", name, c, e_);
      end
      tests_run++;
      if (c_ !== exp_code) begin
        tests_failed++;
        $display("FAIL %s code cycle t+%0d: got %b want %b", name, c, c_, exp_code);
      end
    end
  endtask

  task automatic send(input bit sel, input logic [3:0] d, input string name);
    if (sel) begin din1 = d; dv1 = 1'b1; end
    else     begin din4 = d; dv4 = 1'b1; end
    #1;
    tests_run++;
    if ((sel ? rdy1 : rdy4) !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s din_ready before accept: got %b want 1", name, sel ? rdy1 : rdy4);
    end
    @(posedge clk); #1;
    dv1 = 1'b0;
    dv4 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dv4 = 1'b0; dv1 = 1'b0; din4 = 4'd0; din1 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({rdy4, tx4, busy4, err4, code4} !== 9'b0_1_0_0_00000) begin
      tests_failed++;
      $display("FAIL reset dut4 {rdy,tx,busy,err,code}: got %b want 010000000", {rdy4, tx4, busy4, err4, code4});
    end
    tests_run++;
    if ({rdy1, tx1, busy1, err1, code1} !== 9'b0_1_0_0_00000) begin
      tests_failed++;
      $display("FAIL reset dut1 {rdy,tx,busy,err,code}: got %b want 010000000", {rdy1, tx1, busy1, err1, code1});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({rdy4, rdy1, tx4, tx1} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL reset release {rdy4,rdy1,tx4,tx1}: got %b want 1111", {rdy4, rdy1, tx4, tx1});
    end
  endtask

  task automatic test_digit5();
    send(1'b0, 4'd5, "digit5");
    check_frame(1'b0, 4, 5'b01010, "digit5");
  endtask

  task automatic test_digit7();
    send(1'b0, 4'd7, "digit7");
    check_frame(1'b0, 4, 5'b01111, "digit7");
  endtask

  task automatic test_invalid();
    send(1'b0, 4'd12, "invalid");
    tests_run++;
    if ({err4, tx4, busy4, code4} !== 8'b1_1_0_01111) begin
      tests_failed++;
      $display("FAIL invalid t+1 {err,tx,busy,code}: got %b want 11001111", {err4, tx4, busy4, code4});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({err4, tx4, busy4, rdy4, code4} !== 9'b0_1_0_1_01111) begin
      tests_failed++;
      $display("FAIL invalid t+2 {err,tx,busy,rdy,code}: got %b want 010101111", {err4, tx4, busy4, rdy4, code4});
    end
  endtask

  task automatic test_back_to_back();
    din4 = 4'd3; dv4 = 1'b1;
    @(posedge clk); #1;
    din4 = 4'd9;
    check_frame(1'b0, 4, 5'b00110, "b2b_first");
    @(posedge clk); #1;
    dv4 = 1'b0;
    check_frame(1'b0, 4, 5'b10010, "b2b_second");
  endtask

  task automatic test_reset_mid();
    send(1'b0, 4'd5, "rstmid");
    for (int c = 2; c <= 1 + 3*4; c++) begin @(posedge clk); #1; end
    tests_run++;
    if ({tx4, busy4} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rstmid third bit {tx,busy}: got %b want 01", {tx4, busy4});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({tx4, busy4, err4, rdy4, code4} !== 9'b1_0_0_0_00000) begin
      tests_failed++;
      $display("FAIL rstmid after reset {tx,busy,err,rdy,code}: got %b want 100000000", {tx4, busy4, err4, rdy4, code4});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({rdy4, tx4, busy4} !== 3'b110) begin
      tests_failed++;
      $display("FAIL rstmid after release {rdy,tx,busy}: got %b want 110", {rdy4, tx4, busy4});
    end
    send(1'b0, 4'd1, "rstmid_digit1");
    check_frame(1'b0, 4, 5'b00011, "rstmid_digit1");
  endtask

  task automatic test_n1();
    send(1'b1, 4'd0, "n1_digit0");
    check_frame(1'b1, 1, 5'b00000, "n1_digit0");
    send(1'b1, 4'd9, "n1_digit9");
    check_frame(1'b1, 1, 5'b10010, "n1_digit9");
  endtask

  initial begin
    test_reset();
    test_digit5();
    test_digit7();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_n1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
